// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Streams a program image from a byte source into instruction memory while
//   holding the CPU. Frame format: 16-bit big-endian word count N followed by
//   4*N bytes. Every 4-byte group becomes one big-endian 32-bit word.
//   Words beyond memory capacity are dropped and flag a sticky overflow.
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : one-cycle load request, accepted only in IDLE
//   in_valid  : source presents a byte
//   in_data   : stream byte
//   in_ready  : loader accepts the byte (transfer = in_valid & in_ready)
//   im_we     : instruction-memory word write strobe
//   im_addr   : word-aligned byte address of the write
//   im_wdata  : assembled instruction word
//   cpu_hold  : freezes the CPU while a load is in progress
//   done      : one-cycle pulse at load completion
//   overflow  : sticky, frame carried more words than memory holds
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter int unsigned ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              overflow
);

   localparam int unsigned CAPACITY = 1 << (ADDR_W - 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_WRITE,
      S_DONE
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_count;
   logic [15:0] r_widx;
   logic [1:0]  r_bcnt;
   logic [31:0] r_word;
   logic        r_overflow;

   logic        w_xfer;
   logic        w_full;
   logic        w_last;
   logic [15:0] w_widx_inc;

   assign w_xfer     = in_valid & in_ready;
   assign w_widx_inc = r_widx + 16'd1;
   assign w_last     = (w_widx_inc == r_count);
   // Index at or past capacity: the word is dropped rather than wrapped.
   assign w_full     = (32'(r_widx) >= CAPACITY);

   assign im_wdata = r_word;
   assign overflow = r_overflow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next   = r_state;
      in_ready = 1'b0;
      im_we    = 1'b0;
      im_addr  = '0;
      cpu_hold = 1'b1;
      done     = 1'b0;
      case (r_state)
         S_IDLE: begin
            cpu_hold = 1'b0;
            if (start) w_next = S_LEN_HI;
         end
         S_LEN_HI: begin
            in_ready = 1'b1;
            if (in_valid) w_next = S_LEN_LO;
         end
         S_LEN_LO: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_next = ({r_count[15:8], in_data} == 16'd0) ? S_DONE : S_DATA;
            end
         end
         S_DATA: begin
            in_ready = 1'b1;
            if (in_valid && (r_bcnt == 2'd3)) w_next = S_WRITE;
         end
         S_WRITE: begin
            if (!w_full) begin
               im_we   = 1'b1;
               im_addr = {r_widx[ADDR_W-3:0], 2'b00};
            end
            w_next = w_last ? S_DONE : S_DATA;
         end
         S_DONE: begin
            cpu_hold = 1'b0;
            done     = 1'b1;
            w_next   = S_IDLE;
         end
         default: begin
            cpu_hold = 1'b0;
            w_next   = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count    <= '0;
         r_widx     <= '0;
         r_bcnt     <= '0;
         r_word     <= '0;
         r_overflow <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_count    <= '0;
                  r_widx     <= '0;
                  r_bcnt     <= '0;
                  r_overflow <= 1'b0;
               end
            end
            S_LEN_HI: if (w_xfer) r_count[15:8] <= in_data;
            S_LEN_LO: if (w_xfer) r_count[7:0]  <= in_data;
            S_DATA: begin
               if (w_xfer) begin
                  r_word <= {r_word[23:0], in_data};
                  r_bcnt <= r_bcnt + 2'd1;
               end
            end
            S_WRITE: begin
               r_widx <= w_widx_inc;
               if (w_full) r_overflow <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed self-checking bench for imem_loader. Two instances share the
//   stimulus: one with the default 12-bit address, one with a 4-word memory
//   to exercise the capacity boundary.
// -----------------------------------------------------------------------------
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_data;

   logic        in_ready, im_we, cpu_hold, done, overflow;
   logic [11:0] im_addr;
   logic [31:0] im_wdata;

   logic        in_ready4, im_we4, cpu_hold4, done4, overflow4;
   logic [3:0]  im_addr4;
   logic [31:0] im_wdata4;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int last_we_cyc = 0;
   int ready_viol = 0;
   int timeouts = 0;
   logic hold_at_done = 1'b0;

   logic [31:0] wa[$];
   logic [31:0] wd[$];
   logic [31:0] wa4[$];
   logic [31:0] wd4[$];
   logic [7:0]  frame[$];

   imem_loader dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
      .cpu_hold(cpu_hold), .done(done), .overflow(overflow)
   );

   imem_loader #(.ADDR_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready4), .im_we(im_we4), .im_addr(im_addr4), .im_wdata(im_wdata4),
      .cpu_hold(cpu_hold4), .done(done4), .overflow(overflow4)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (im_we) begin
         wa.push_back(32'(im_addr));
         wd.push_back(im_wdata);
         last_we_cyc = cyc;
         if (in_ready) ready_viol++;
         if (!cpu_hold) ready_viol++;
      end
      if (im_we4) begin
         wa4.push_back(32'(im_addr4));
         wd4.push_back(im_wdata4);
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         hold_at_done = cpu_hold;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      wa.delete(); wd.delete(); wa4.delete(); wd4.delete();
      done_cnt   = 0;
      ready_viol = 0;
      timeouts   = 0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Presents one byte and holds it until the loader takes it.
   task automatic send_byte(input logic [7:0] b, input bit gap);
      int n = 0;
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) timeouts++;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (gap) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic send_frame(input bit gap);
      foreach (frame[i]) send_byte(frame[i], gap);
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (done_cnt < target && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("done_seen", 32'(done_cnt), 32'(target));
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_im_we",    32'(im_we),    0);
      chk("rst_im_addr",  32'(im_addr),  0);
      chk("rst_im_wdata", im_wdata,      0);
      chk("rst_cpu_hold", 32'(cpu_hold), 0);
      chk("rst_done",     32'(done),     0);
      chk("rst_overflow", 32'(overflow), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_in_ready", 32'(in_ready), 0);

      // Two-word frame, back-to-back bytes.
      clear_log();
      do_start();
      chk("t1_hold_after_start", 32'(cpu_hold), 1);
      frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
      send_frame(1'b0);
      wait_done(1);
      chk("t1_nwrites", 32'(wa.size()), 2);
      chk("t1_addr0", wa[0], 32'h000);
      chk("t1_data0", wd[0], 32'h20080005);
      chk("t1_addr1", wa[1], 32'h004);
      chk("t1_data1", wd[1], 32'hAC080000);
      chk("t1_done_after_write", 32'(done_cyc), 32'(last_we_cyc + 1));
      chk("t1_hold_at_done", 32'(hold_at_done), 0);
      chk("t1_hold_after", 32'(cpu_hold), 0);
      chk("t1_overflow", 32'(overflow), 0);
      chk("t1_ready_in_write", 32'(ready_viol), 0);
      chk("t1_stall", 32'(timeouts), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("t1_done_once", 32'(done_cnt), 1);

      // Zero-length frame.
      clear_log();
      do_start();
      frame = '{8'h00, 8'h00};
      send_frame(1'b0);
      chk("t2_done_now", 32'(done), 1);
      wait_done(1);
      chk("t2_nwrites", 32'(wa.size()), 0);
      chk("t2_overflow", 32'(overflow), 0);

      // Same two-word frame with in_valid toggling.
      clear_log();
      do_start();
      frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
      send_frame(1'b1);
      wait_done(1);
      chk("t3_nwrites", 32'(wa.size()), 2);
      chk("t3_addr0", wa[0], 32'h000);
      chk("t3_data0", wd[0], 32'h20080005);
      chk("t3_addr1", wa[1], 32'h004);
      chk("t3_data1", wd[1], 32'hAC080000);
      chk("t3_ready_in_write", 32'(ready_viol), 0);
      chk("t3_stall", 32'(timeouts), 0);

      // start pulsed mid-DATA, plus an idle gap, must not disturb the frame.
      clear_log();
      do_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h20, 1'b0);
      send_byte(8'h08, 1'b0);
      do_start();
      repeat (2) @(posedge clk);
      #1;
      chk("t4_hold_mid", 32'(cpu_hold), 1);
      frame = '{8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
      send_frame(1'b0);
      wait_done(1);
      chk("t4_nwrites", 32'(wa.size()), 2);
      chk("t4_data0", wd[0], 32'h20080005);
      chk("t4_addr1", wa[1], 32'h004);
      chk("t4_data1", wd[1], 32'hAC080000);

      // Five words into a four-word memory (dut4); dut holds all five.
      clear_log();
      do_start();
      send_byte(8'h00, 1'b0);
      send_byte(8'h05, 1'b0);
      for (int w = 1; w <= 5; w++) begin
         for (int k = 0; k < 4; k++) send_byte(8'(w * 17), 1'b0);
      end
      wait_done(1);
      chk("t5_nwrites4", 32'(wa4.size()), 4);
      for (int i = 0; i < 4; i++) begin
         logic [7:0] bv;
         bv = 8'((i + 1) * 17);
         chk($sformatf("t5_addr4_%0d", i), wa4[i], 32'(i * 4));
         chk($sformatf("t5_data4_%0d", i), wd4[i], {bv, bv, bv, bv});
      end
      chk("t5_overflow4", 32'(overflow4), 1);
      chk("t5_nwrites12", 32'(wa.size()), 5);
      chk("t5_addr12_4", wa[4], 32'h010);
      chk("t5_data12_4", wd[4], 32'h55555555);
      chk("t5_overflow12", 32'(overflow), 0);
      repeat (4) @(posedge clk);
      #1;
      chk("t5_overflow4_sticky", 32'(overflow4), 1);
      do_start();
      chk("t5_overflow4_clear", 32'(overflow4), 0);
      clear_log();
      frame = '{8'h00, 8'h00};
      send_frame(1'b0);
      wait_done(1);

      // Asynchronous reset mid-word, then a clean reload.
      clear_log();
      do_start();
      frame = '{8'h00, 8'h01, 8'hAA, 8'hBB};
      send_frame(1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_in_ready", 32'(in_ready), 0);
      chk("t6_im_we", 32'(im_we), 0);
      chk("t6_im_addr", 32'(im_addr), 0);
      chk("t6_im_wdata", im_wdata, 0);
      chk("t6_cpu_hold", 32'(cpu_hold), 0);
      chk("t6_done", 32'(done), 0);
      chk("t6_overflow", 32'(overflow), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("t6_nwrites_reset", 32'(wa.size()), 0);
      do_start();
      frame = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      send_frame(1'b0);
      wait_done(1);
      chk("t6_nwrites", 32'(wa.size()), 1);
      chk("t6_addr0", wa[0], 32'h000);
      chk("t6_data0", wd[0], 32'hDEADBEEF);
      chk("t6_stall", 32'(timeouts), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
